// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that assembles NUM_BYTES bytes into one atomic frame, with error reporting.
// Define UART_FRAME_CHECKSUM_EN to make the last byte an XOR checksum of the others (NUM_BYTES >= 2).
module uart_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_BYTES    = 7,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rxd,
  output logic [8*NUM_BYTES-1:0]             frame_data,
  output logic                               frame_valid,
  output logic                               frame_err,
  output logic [1:0]                         err_code,
  output logic                               busy,
  output logic [$clog2(NUM_BYTES+1)-1:0]     byte_cnt
);

  localparam int unsigned FW       = 8 * NUM_BYTES;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BC_W     = $clog2(NUM_BYTES + 1);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [1:0] ERR_FRAMING  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state_q;
  logic              meta_q, rxs_q, rxs_prev_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic [FW-1:0]     buf_q;
  logic [TO_W-1:0]   idle_cnt_q;
  logic [FW-1:0]     frame_data_q;
  logic              frame_valid_q, frame_err_q, busy_q;
  logic [1:0]        err_code_q;
  logic [BC_W-1:0]   byte_cnt_q;

  logic              fall_c, mid_c, half_c, last_byte_c, timeout_c, ck_fail_c;
  logic              stop_mid_c, accept_c, framing_c;
  logic [FW-1:0]     buf_next_c;

  assign fall_c      = rxs_prev_q & ~rxs_q;
  assign mid_c       = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_c      = (cnt_q == CNT_W'(CLKS_PER_BIT / 2));
  assign last_byte_c = (byte_cnt_q == BC_W'(NUM_BYTES - 1));
  assign timeout_c   = (state_q == S_IDLE) && !fall_c && busy_q &&
                       (idle_cnt_q == TO_W'(TO_LIMIT - 1));
  assign stop_mid_c  = (state_q == S_STOP) && mid_c;
  assign accept_c    = stop_mid_c && rxs_q;
  assign framing_c   = stop_mid_c && !rxs_q;
  // Bytes shift in from the bottom, so the first byte ends up in the top slot.
  assign buf_next_c  = (buf_q << 8) | FW'(shift_q);

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] acc_q;

  // Running XOR of the bytes accepted so far in the current frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (framing_c || timeout_c || (accept_c && last_byte_c)) begin
      acc_q <= '0;
    end else if (accept_c) begin
      acc_q <= acc_q ^ shift_q;
    end
  end

  assign ck_fail_c = (acc_q != shift_q);
`else
  assign ck_fail_c = 1'b0;
`endif

  // Synchroniser, bit FSM, frame assembly and error handling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q        <= 1'b1;
      rxs_q         <= 1'b1;
      rxs_prev_q    <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      buf_q         <= '0;
      idle_cnt_q    <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'b00;
      busy_q        <= 1'b0;
      byte_cnt_q    <= '0;
    end else begin
      meta_q        <= rxd;
      rxs_q         <= meta_q;
      rxs_prev_q    <= rxs_q;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (fall_c) begin
            state_q    <= S_START;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
          end else if (timeout_c) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
            byte_cnt_q  <= '0;
            busy_q      <= 1'b0;
            idle_cnt_q  <= '0;
          end else if (busy_q) begin
            idle_cnt_q <= idle_cnt_q + TO_W'(1);
          end else begin
            idle_cnt_q <= '0;
          end
        end

        S_START: begin
          if (half_c) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (rxs_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
              busy_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (mid_c) begin
            cnt_q   <= '0;
            shift_q <= {rxs_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (mid_c) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (!rxs_q) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_FRAMING;
              byte_cnt_q  <= '0;
              busy_q      <= 1'b0;
            end else if (last_byte_c) begin
              byte_cnt_q <= '0;
              busy_q     <= 1'b0;
              if (ck_fail_c) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_CHECKSUM;
              end else begin
                frame_data_q  <= buf_next_c;
                frame_valid_q <= 1'b1;
              end
            end else begin
              buf_q      <= buf_next_c;
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = busy_q;
  assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: scoreboard of expected frame/error events plus per-scenario checks.
module tb_uart_frame_rx;

  localparam int unsigned CPB  = 8;
  localparam int unsigned NB   = 7;
  localparam int unsigned TOB  = 20;
  localparam int unsigned FW   = 8 * NB;
  localparam int unsigned BCW  = $clog2(NB + 1);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           rxd;
  logic [FW-1:0]  frame_data;
  logic           frame_valid;
  logic           frame_err;
  logic [1:0]     err_code;
  logic           busy;
  logic [BCW-1:0] byte_cnt;

  always #5 clk = ~clk;

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_code(err_code), .busy(busy), .byte_cnt(byte_cnt)
  );

  typedef struct {
    bit            is_err;
    logic [FW-1:0] data;
    logic [1:0]    code;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [FW-1:0] last_good = '0;
  logic [1:0]    last_code = 2'b00;

  // Every frame_valid / frame_err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst === 1'b1 && (frame_valid === 1'b1 || frame_err === 1'b1)) begin
      n_checks++;
      if (frame_valid === 1'b1 && frame_err === 1'b1) begin
        $display("FAIL pulse_overlap: frame_valid and frame_err both high at %0t", $time);
      end else if (sb.size() == 0) begin
        $display("FAIL unexpected_event: valid=%b err=%b code=%b with nothing expected at %0t",
                 frame_valid, frame_err, err_code, $time);
      end else begin
        mon_e = sb.pop_front();
        if (frame_err !== mon_e.is_err)
          $display("FAIL event_kind: got err=%b want err=%b at %0t", frame_err, mon_e.is_err, $time);
        else if (mon_e.is_err && err_code !== mon_e.code)
          $display("FAIL err_code_event: got %b want %b at %0t", err_code, mon_e.code, $time);
        else if (!mon_e.is_err && frame_data !== mon_e.data)
          $display("FAIL frame_data_event: got %h want %h at %0t", frame_data, mon_e.data, $time);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.data = '0; e.code = code;
    last_code = code;
    sb.push_back(e);
  endtask

  // Model: a frame is good unless checksumming is on and the XOR of all bytes is non-zero.
  task automatic push_frame(input logic [FW-1:0] f);
    exp_t       e;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NB; i++) x = x ^ f[FW-1-8*i -: 8];
    if (CK && x != 8'h00) begin
      push_err(2'b11);
    end else begin
      e.is_err = 1'b0; e.data = f; e.code = 2'b00;
      last_good = f;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [FW-1:0] f);
    push_frame(f);
    for (int i = 0; i < NB; i++) send_byte(f[FW-1-8*i -: 8], 1'b1);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rxd = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (frame_data !== '0)    $display("FAIL reset_frame_data: got %h want 0", frame_data); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL reset_frame_valid: got %b want 0", frame_valid); else n_pass++;
    n_checks++; if (frame_err !== 1'b0)   $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
    n_checks++; if (err_code !== 2'b00)   $display("FAIL reset_err_code: got %b want 00", err_code); else n_pass++;
    n_checks++; if (busy !== 1'b0)        $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (byte_cnt !== '0)      $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); else n_pass++;
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame;
    logic [FW-1:0] f;
    f = 56'h01C83200030105;
    push_frame(f);
    for (int i = 0; i < NB; i++) begin
      send_byte(f[FW-1-8*i -: 8], 1'b1);
      if (i == 2) begin
        n_checks++; if (byte_cnt !== BCW'(3)) $display("FAIL frame_byte_cnt3: got %0d want 3", byte_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b1)        $display("FAIL frame_busy_mid: got %b want 1", busy); else n_pass++;
      end
    end
    wait_drain(20);
    n_checks++; if (sb.size() != 0)       $display("FAIL frame_drain: got %0d pending want 0", sb.size()); else n_pass++;
    n_checks++; if (frame_data !== last_good) $display("FAIL frame_data: got %h want %h", frame_data, last_good); else n_pass++;
    n_checks++; if (err_code !== last_code)   $display("FAIL frame_err_code: got %b want %b", err_code, last_code); else n_pass++;
    n_checks++; if (byte_cnt !== '0 || busy !== 1'b0)
      $display("FAIL frame_end_state: got cnt=%0d busy=%b want 0/0", byte_cnt, busy); else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timeout;
    push_err(2'b10);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    n_checks++; if (byte_cnt !== BCW'(3) || busy !== 1'b1)
      $display("FAIL timeout_partial: got cnt=%0d busy=%b want 3/1", byte_cnt, busy); else n_pass++;
    repeat (TOB * CPB - 10) @(negedge clk);
    n_checks++; if (sb.size() != 1) $display("FAIL timeout_early: got %0d pending want 1", sb.size()); else n_pass++;
    wait_drain(40);
    n_checks++; if (sb.size() != 0) $display("FAIL timeout_late: got %0d pending want 0", sb.size()); else n_pass++;
    n_checks++; if (err_code !== 2'b10) $display("FAIL timeout_err_code: got %b want 10", err_code); else n_pass++;
    n_checks++; if (frame_data !== last_good) $display("FAIL timeout_frame_kept: got %h want %h", frame_data, last_good); else n_pass++;
    n_checks++; if (byte_cnt !== '0 || busy !== 1'b0)
      $display("FAIL timeout_state: got cnt=%0d busy=%b want 0/0", byte_cnt, busy); else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_framing;
    push_err(2'b01);
    send_byte(8'h3C, 1'b0);
    wait_drain(20);
    n_checks++; if (sb.size() != 0)     $display("FAIL framing_drain: got %0d pending want 0", sb.size()); else n_pass++;
    n_checks++; if (err_code !== 2'b01) $display("FAIL framing_err_code: got %b want 01", err_code); else n_pass++;
    n_checks++; if (byte_cnt !== '0 || busy !== 1'b0)
      $display("FAIL framing_state: got cnt=%0d busy=%b want 0/0", byte_cnt, busy); else n_pass++;
    repeat (20) @(negedge clk);
    send_frame(56'hA55A00FF817E3C);
    wait_drain(20);
    n_checks++; if (sb.size() != 0) $display("FAIL framing_next_drain: got %0d pending want 0", sb.size()); else n_pass++;
    n_checks++; if (frame_data !== last_good) $display("FAIL framing_next_frame: got %h want %h", frame_data, last_good); else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch;
    bit busy_seen;
    busy_seen = 1'b0;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 5 * CPB; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    n_checks++; if (busy_seen !== 1'b0) $display("FAIL glitch_busy: got busy seen=1 want 0"); else n_pass++;
    n_checks++; if (byte_cnt !== '0)    $display("FAIL glitch_byte_cnt: got %0d want 0", byte_cnt); else n_pass++;
    n_checks++; if (err_code !== last_code) $display("FAIL glitch_err_code: got %b want %b", err_code, last_code); else n_pass++;
  endtask

  task automatic test_reset_mid;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    last_good = '0;
    last_code = 2'b00;
    n_checks++; if (frame_data !== '0) $display("FAIL rstmid_frame_data: got %h want 0", frame_data); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL rstmid_pulses: got valid=%b err=%b want 0/0", frame_valid, frame_err); else n_pass++;
    n_checks++; if (err_code !== 2'b00 || busy !== 1'b0 || byte_cnt !== '0)
      $display("FAIL rstmid_state: got code=%b busy=%b cnt=%0d want 00/0/0", err_code, busy, byte_cnt); else n_pass++;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(56'h10203040506070);
    wait_drain(20);
    n_checks++; if (sb.size() != 0) $display("FAIL rstmid_drain: got %0d pending want 0", sb.size()); else n_pass++;
    n_checks++; if (frame_data !== 56'h10203040506070)
      $display("FAIL rstmid_frame: got %h want 10203040506070", frame_data); else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_break;
    push_err(2'b01);
    rxd = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    n_checks++; if (sb.size() != 0) $display("FAIL break_framing: got %0d pending want 0", sb.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0)  $display("FAIL break_busy_low: got %b want 0", busy); else n_pass++;
    rxd = 1'b1;
    repeat ((TOB + 5) * CPB) @(negedge clk);
    n_checks++; if (err_code !== 2'b01 || busy !== 1'b0)
      $display("FAIL break_after: got code=%b busy=%b want 01/0", err_code, busy); else n_pass++;
  endtask

`ifdef UART_FRAME_CHECKSUM_EN
  task automatic test_checksum;
    send_frame(56'h01020304050608);
    wait_drain(20);
    n_checks++; if (err_code !== 2'b11) $display("FAIL cksum_bad: got %b want 11", err_code); else n_pass++;
    send_frame(56'h01020304050607);
    wait_drain(20);
    n_checks++; if (sb.size() != 0) $display("FAIL cksum_drain: got %0d pending want 0", sb.size()); else n_pass++;
    n_checks++; if (frame_data !== 56'h01020304050607)
      $display("FAIL cksum_good: got %h want 01020304050607", frame_data); else n_pass++;
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_break();
`ifdef UART_FRAME_CHECKSUM_EN
    test_checksum();
`endif
    repeat (20) @(negedge clk);
    n_checks++; if (sb.size() != 0) $display("FAIL final_scoreboard: got %0d pending want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
